audio_pwm_out: RTL and testbench

Audio output stage: accepts unsigned PCM samples over a valid/ready stream, buffers them in a small FIFO and emits one sample per fixed-length PWM frame on a single-bit output plus an amplifier-enable line. Sits directly downstream of the sound generator and drives the board's mono audio jack pins (PWM and shutdown). Optional soft ramp to/from midscale suppresses pops on enable/disable.

---
 rtl/audio_pwm_out_if.sv | 12 +
 rtl/audio_pwm_out.sv | 160 ++++++++++++++++
 tb/tb_audio_pwm_out.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pwm_out_if.sv
// Sample stream between the sound generator and the PWM output stage.
// The source drives s_data/s_valid; the sink answers with s_ready.
interface audio_pwm_out_if #(
  parameter int SAMPLE_W = 8
);
  logic [SAMPLE_W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/audio_pwm_out.sv
// PCM-to-PWM audio output: sample FIFO, one sample per 2^SAMPLE_W-clock frame, amp enable.
// Define AUDIO_SOFT_RAMP_EN to add the pop-suppressing duty ramp to/from midscale.
module audio_pwm_out #(
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  audio_pwm_out_if.slave              s,
  output logic                        pwm_out,
  output logic                        aud_sd,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [SAMPLE_W-1:0] MID_DUTY = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] duty;
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  logic fb;
  logic fifo_empty;
  logic push;
  logic pop;
  logic flush;

  assign fb         = &cnt;
  assign fifo_empty = (fifo_level == '0);

  // s_ready comes from registered state and level only, so a push can never land on a full FIFO.
  assign s.s_ready = ((state == RAMP_UP) || (state == RUN)) && (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push      = s.s_valid && s.s_ready;
  assign pop       = fb && (state == RUN) && enable && !fifo_empty;
  assign flush     = fb && (state == RUN) && !enable;

  // NOTE: every clocked block uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered compare: output in the cycle after cnt == k is (k < duty).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cnt < duty);
    end
  end

  // NOTE: the sample storage has no reset; only pointers and level are reset, which makes it empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s.s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Control FSM: every decision is taken at the frame boundary, so duty only changes between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      duty     <= '0;
      aud_sd   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fb) begin
        case (state)
          IDLE: begin
            if (enable) begin
              aud_sd <= 1'b1;
`ifdef AUDIO_SOFT_RAMP_EN
              state  <= RAMP_UP;
`else
              state  <= RUN;
              duty   <= MID_DUTY;
`endif
            end
          end
`ifdef AUDIO_SOFT_RAMP_EN
          RAMP_UP: begin
            if (!enable) begin
              state <= RAMP_DOWN;
            end else if (duty < MID_DUTY) begin
              duty <= duty + 1'b1;
              if (duty == MID_DUTY - 1'b1) state <= RUN;
            end else begin
              // Re-entered above midscale after a loud sample: hand straight over to RUN.
              state <= RUN;
            end
          end
          RAMP_DOWN: begin
            if (enable) begin
              state <= RAMP_UP;
            end else if (duty == '0) begin
              state  <= IDLE;
              aud_sd <= 1'b0;
            end else begin
              duty <= duty - 1'b1;
            end
          end
`endif
          RUN: begin
            if (!enable) begin
`ifdef AUDIO_SOFT_RAMP_EN
              state  <= RAMP_DOWN;
`else
              state  <= IDLE;
              duty   <= '0;
              aud_sd <= 1'b0;
`endif
            end else if (!fifo_empty) begin
              duty <= mem[rd_ptr];
            end else begin
              underrun <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            duty   <= '0;
            aud_sd <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: per-frame PWM high counts and underrun pulses are scoreboarded,
// handshake/level/amp-enable values are checked directly at chosen frame positions.
module tb_audio_pwm_out;
  localparam int SAMPLE_W   = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pwm_out;
  logic       aud_sd;
  logic       underrun;
  logic [2:0] fifo_level;

  audio_pwm_out_if #(.SAMPLE_W(SAMPLE_W)) snd ();

  audio_pwm_out #(.SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .s          (snd),
    .pwm_out    (pwm_out),
    .aud_sd     (aud_sd),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int frame;
    int highs;
    int unders;
  } exp_t;
  exp_t exp_q[$];

  // Frame position reference: the frame counter restarts at reset and free-runs.
  logic [7:0] tb_cnt;
  int         tb_frame;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tb_cnt   <= '0;
      tb_frame <= 0;
    end else begin
      tb_cnt <= tb_cnt + 8'd1;
      if (tb_cnt == 8'hFF) tb_frame <= tb_frame + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d (frame %0d cnt %0d)", name, act, exp, tb_frame, tb_cnt);
    end
  endtask

  task automatic expect_frame(input int f, input int h, input int u);
    exp_q.push_back(exp_t'{frame: f, highs: h, unders: u});
  endtask

  // Monitor: the PWM window of frame F is cnt 1..255 of F plus cnt 0 of F+1;
  // the underrun window of frame F is cnt 0..255 of F.
  int hi = 0;
  int ur = 0;
  always @(negedge clk) begin
    if (reset) begin
      hi = 0;
      ur = 0;
    end else if (tb_cnt == 8'd0 && tb_frame != 0) begin
      hi += int'(pwm_out);
      if (exp_q.size() > 0 && exp_q[0].frame == tb_frame - 1) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("pwm highs frame %0d", e.frame), hi, e.highs);
        check($sformatf("underrun frame %0d", e.frame), ur, e.unders);
      end
      hi = 0;
      ur = int'(underrun);
    end else begin
      hi += int'(pwm_out);
      ur += int'(underrun);
    end
  end

  task automatic goto(input int f, input int c);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(tb_frame == f && int'(tb_cnt) == c) && n < 90000);
    if (n >= 90000) begin
      $display("FAIL goto: frame %0d cnt %0d never reached", f, c);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
    end
  endtask

  task automatic push_sample(input logic [7:0] d);
    int   n = 0;
    logic rdy;
    snd.s_data  = d;
    snd.s_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = snd.s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 600);
    snd.s_valid = 1'b0;
    check($sformatf("push 0x%02h accepted", d), rdy, 1);
  endtask

  task automatic reset_values(input string tag);
    check({tag, " pwm_out"}, pwm_out, 0);
    check({tag, " aud_sd"}, aud_sd, 0);
    check({tag, " s_ready"}, snd.s_ready, 0);
    check({tag, " underrun"}, underrun, 0);
    check({tag, " fifo_level"}, fifo_level, 0);
  endtask

  // Fill 3 samples in frame f, then hit reset mid-frame and confirm nothing resumes.
  task automatic reset_tail(input int f, input logic pwm_before);
    goto(f, 10);
    push_sample(8'h01);
    push_sample(8'h02);
    push_sample(8'h03);
    goto(f, 50);
    check("level before reset", fifo_level, 3);
    goto(f, 100);
    check("pwm before reset", pwm_out, pwm_before);
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    reset_values("mid-run reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_frame(0, 0, 0);
    expect_frame(1, 0, 0);
    goto(2, 5);
    check("post-reset aud_sd", aud_sd, 0);
    check("post-reset level", fifo_level, 0);
    check("post-reset s_ready", snd.s_ready, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    snd.s_data  = '0;
    snd.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_values("in reset");
    reset = 1'b0;

`ifdef AUDIO_SOFT_RAMP_EN
    expect_frame(0, 0, 0);
    for (int f = 1; f <= 128; f++) expect_frame(f, f - 1, 0);
    expect_frame(129, 128, 0);
    goto(0, 100);
    enable = 1'b1;
    goto(1, 2);
    check("ramp-up aud_sd", aud_sd, 1);
    check("ramp-up s_ready", snd.s_ready, 1);
    goto(128, 2);
    check("late ramp aud_sd", aud_sd, 1);
    goto(129, 10);
    push_sample(8'hAA);
    push_sample(8'hBB);
    goto(129, 50);
    check("run level", fifo_level, 2);
    goto(129, 100);
    enable = 1'b0;
    for (int f = 130; f <= 194; f++) expect_frame(f, 128 - (f - 130), 0);
    for (int f = 195; f <= 197; f++) expect_frame(f, 64 + (f - 195), 0);
    for (int f = 198; f <= 264; f++) expect_frame(f, 66 - (f - 198), 0);
    expect_frame(265, 0, 0);
    goto(130, 5);
    check("ramp-down flushed level", fifo_level, 0);
    check("ramp-down s_ready", snd.s_ready, 0);
    check("ramp-down aud_sd", aud_sd, 1);
    goto(194, 100);
    enable = 1'b1;
    goto(195, 5);
    check("re-ramp s_ready", snd.s_ready, 1);
    goto(197, 100);
    enable = 1'b0;
    goto(264, 200);
    check("last ramp frame aud_sd", aud_sd, 1);
    goto(265, 5);
    check("idle aud_sd", aud_sd, 0);
    check("idle s_ready", snd.s_ready, 0);
    goto(265, 100);
    enable = 1'b1;
    reset_tail(266, 1'b0);
`else
    expect_frame(0, 0, 0);
    expect_frame(1, 128, 0);
    expect_frame(2, 0, 0);
    expect_frame(3, 64, 0);
    expect_frame(4, 255, 0);
    expect_frame(5, 255, 1);
    expect_frame(6, 8'h11, 0);
    expect_frame(7, 8'h22, 0);
    expect_frame(8, 8'h33, 0);
    expect_frame(9, 8'h44, 0);
    expect_frame(10, 8'h55, 0);
    expect_frame(11, 8'h66, 0);
    expect_frame(12, 8'h66, 1);
    expect_frame(13, 0, 0);

    goto(0, 100);
    enable = 1'b1;
    goto(1, 2);
    check("run aud_sd", aud_sd, 1);
    check("run s_ready", snd.s_ready, 1);
    goto(1, 10);
    push_sample(8'h00);
    push_sample(8'h40);
    push_sample(8'hFF);
    goto(1, 50);
    check("three queued", fifo_level, 3);

    goto(5, 10);
    push_sample(8'h11);
    push_sample(8'h22);
    push_sample(8'h33);
    push_sample(8'h44);
    snd.s_data  = 8'h55;
    snd.s_valid = 1'b1;
    goto(5, 200);
    check("full level", fifo_level, 4);
    check("full s_ready", snd.s_ready, 0);
    goto(6, 1);
    snd.s_valid = 1'b0;
    goto(6, 10);
    check("refill after pop", fifo_level, 4);

    goto(7, 255);
    check("s_ready at level 3", snd.s_ready, 1);
    snd.s_data  = 8'h66;
    snd.s_valid = 1'b1;
    goto(8, 0);
    snd.s_valid = 1'b0;
    check("push+pop level", fifo_level, 3);

    goto(12, 10);
    push_sample(8'h77);
    push_sample(8'h88);
    goto(12, 50);
    check("two queued before disable", fifo_level, 2);
    goto(12, 100);
    enable = 1'b0;
    goto(12, 200);
    check("aud_sd before disable FB", aud_sd, 1);
    goto(13, 5);
    check("disable flushed level", fifo_level, 0);
    check("disable s_ready", snd.s_ready, 0);
    check("disable aud_sd", aud_sd, 0);
    goto(13, 10);
    snd.s_data  = 8'h99;
    snd.s_valid = 1'b1;
    goto(13, 20);
    snd.s_valid = 1'b0;
    goto(13, 30);
    check("idle ignores s_valid", fifo_level, 0);
    goto(13, 100);
    enable = 1'b1;
    goto(14, 5);
    check("re-enable aud_sd", aud_sd, 1);
    reset_tail(14, 1'b1);
`endif

    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
